booth_mul_arbiter: RTL and testbench
====================================

# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one Booth multiplier instance (`Booths`: `A`, `B`, `start`, `done`, `M`) among `NREQ` requesters. It accepts operand pairs, issues a one-cycle `start` pulse, waits for `done`, captures the product and returns it to the winning requester. It sits between the client blocks and the multiplier, and is the only driver of the multiplier's `A`, `B` and `start`. The multiplier shares this block's clock and reset.

## Interface
- `NREQ`, 4: number of requesters, 2 to 8.
- `WIDTH`, 8: operand width. The product is 2·`WIDTH` bits.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only with `BOOTH_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_a`  in  NREQ·WIDTH  operand A; requester i occupies bits [i·WIDTH +: WIDTH].
- `req_b`  in  NREQ·WIDTH  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `resp_valid`  out  NREQ  one-hot result strobe, one cycle long.
- `resp_m`  out  2·WIDTH  product; valid while any `resp_valid` bit is high.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `mul_a`, `mul_b`  out  WIDTH  operands to the multiplier, registered.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_done`  in  1  multiplier done.
- `mul_m`  in  2·WIDTH  multiplier product.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Compute the grant `g` as the first set `req_valid` bit, searching circularly from `ptr`.
  - `req_ready[g]` is asserted combinationally, only in IDLE and only when `req_valid` is nonzero.
  - On accept, latch `req_a[g]` into `mul_a`, `req_b[g]` into `mul_b`, and `g` into `owner`; set `ptr` to (g+1) mod NREQ; go to ISSUE.
- **ISSUE**
  - Assert `mul_start` for exactly one cycle; go to WAIT.
- **WAIT**
  - `mul_done` is ignored during the ISSUE cycle.
  - On the first cycle in WAIT with `mul_done`=1, capture `mul_m` into `resp_m`; go to RESP.
- **RESP**
  - Assert `resp_valid[owner]` for one cycle; go to IDLE.
  - The response has no backpressure; the requester must sample it in that cycle.
- **Operand stability:** `mul_a`/`mul_b` stay stable from ISSUE until the cycle RESP ends.
- **Request hold rule:** requests not granted stay pending. A requester must hold `req_valid` and its operands stable until it sees `req_ready`.
- **Simultaneous requests:** strict round-robin. With all requesters active and `ptr`=0, the grant order is 0, 1, 2, 3, 0, …
- **Requester reuse:** a requester may raise `req_valid` again in the same cycle it receives its `resp_valid`.
- **Arithmetic:** `resp_m` equals `mul_m` bit for bit. This block applies no sign or width manipulation.
- **Reset (asynchronous, any state, including mid-WAIT):**
  - State goes to IDLE; `ptr` and `owner` go to 0.
  - `mul_a`, `mul_b`, `mul_start`, `resp_valid`, `resp_m` and `resp_err` go to 0.
  - `req_ready` is 0 while `reset` is low.
  - Any in-flight operation is dropped with no response.

## Timing
- Accept at cycle T (IDLE) → `mul_start` at T+1 → WAIT from T+2.
- If `mul_done` is first seen at cycle D ≥ T+2 → `resp_valid` at D+1 → IDLE at D+2.
- Back-to-back throughput is one operation per (multiplier latency + 3) cycles.

## Configuration
- **`BOOTH_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` with no `mul_done`, go to RESP with `resp_m`=0 and `resp_err`=1.
  - A `mul_done` arriving in the same cycle the counter reaches `TIMEOUT` wins: normal response, `resp_err`=0.
- **Macro not defined:** no counter. WAIT waits indefinitely and `resp_err` is tied to 0.

## Test plan
- **Reset:** hold `reset`=0 for 20 ns. All outputs are 0. Release with `req_valid`=0; the FSM stays in IDLE with no `mul_start`.
- **Single request:** requester 0 sends A=7, B=3. Expect one `mul_start` pulse and `resp_valid`=4'b0001 with `resp_m`=21, at accept + latency + 3.
- **Contention:** all four requesters request together, with operands (12,5), (25,10), (7,3), (100,100). Expect `resp_valid` order 0, 1, 2, 3 and `resp_m` = 60, 250, 21, 10000.
- **Round-robin fairness:** requesters 1 and 3 request continuously from reset. Grants must alternate 1, 3, 1, 3; neither is starved.
- **Reset mid-operation:** pull `reset` low during WAIT for requester 2's operation. Expect no `resp_valid`, all outputs 0, and `ptr`=0. A new request after release completes normally.
- **Timeout (with `BOOTH_ARB_TIMEOUT_EN`):** stub `mul_done`=0 and set `TIMEOUT`=16. Expect `resp_valid` 17 cycles after entering WAIT, with `resp_err`=1 and `resp_m`=0.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin arbiter/sequencer sharing one Booth multiplier
// among NREQ requesters. Accept -> start pulse -> wait for done -> one-cycle
// response to the granted requester.
// Optional watchdog: define BOOTH_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT
// cycles with resp_err=1 and resp_m=0. Without it resp_err is tied to 0.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]      resp_m,
  output logic                    resp_err,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_m
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic [MW-1:0]     resp_m_q, resp_m_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              resp_err_q, resp_err_d;
`endif

  logic [PW:0]       cand_s;
  logic [PW-1:0]     grant_idx_s;
  logic              grant_hit_s;
  logic              accept_s;
  logic [NREQ-1:0]   req_ready_s;

  // Circular search from ptr for the first pending request; ready is gated by reset
  always_comb begin
    cand_s      = '0;
    grant_idx_s = '0;
    grant_hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand_s >= (PW+1)'(NREQ)) begin
        cand_s = cand_s - (PW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_hit_s && req_valid[cand_s[PW-1:0]]) begin
        grant_hit_s = 1'b1;
        grant_idx_s = cand_s[PW-1:0];
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
    accept_s    = (state_q == ST_IDLE) && grant_hit_s && reset;
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state and next-output computation for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_start_d  = 1'b0;
    resp_valid_d = '0;
    resp_m_d     = resp_m_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          mul_a_d     = req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
          mul_b_d     = req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
          owner_d     = grant_idx_s;
          ptr_d       = (grant_idx_s == PW'(NREQ - 1)) ? '0 : grant_idx_s + PW'(1);
          mul_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Any mul_done seen here belongs to nothing we issued; ignore it.
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          resp_m_d              = mul_m;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = ST_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT)) begin
          resp_m_d              = '0;
          resp_err_d            = 1'b1;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_WAIT;
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operands and response registers; async reset drops any operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_m_q     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_start_q  <= mul_start_d;
      resp_valid_q <= resp_valid_d;
      resp_m_q     <= resp_m_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_m     = resp_m_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_start  = mul_start_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Testbench for booth_mul_arbiter: behavioural multiplier stub, table-driven
// single operations, scoreboard of expected responses, and hand-written
// contention / fairness / reset / watchdog sequences.
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TO   = 16;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_a;
  logic [NREQ*W-1:0]    req_b;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [2*W-1:0]       resp_m;
  logic                 resp_err;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*W-1:0]       mul_m;

  booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_m(resp_m), .resp_err(resp_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done), .mul_m(mul_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: done is high exactly lat+1 cycles after the start cycle
  int             lat = 3;
  bit             stub_dead = 1'b0;
  int             mcnt;
  logic [2*W-1:0] mprod;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt     <= 0;
      mul_done <= 1'b0;
      mul_m    <= 16'h0000;
      mprod    <= 16'h0000;
    end else begin
      mul_done <= 1'b0;
      mul_m    <= 16'hA5A5;
      if (mul_start) begin
        mcnt  <= lat;
        mprod <= {8'h00, mul_a} * {8'h00, mul_b};
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !stub_dead) begin
          mul_done <= 1'b1;
          mul_m    <= mprod;
        end
      end
    end
  end

  typedef struct {
    int             idx;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] m;
    logic           err;
    int             lat;
    int             acc;
  } sb_t;

  typedef struct {
    int             idx;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] m;
    int             lat;
  } vec_t;

  sb_t            sbq[$];
  int             grant_log[$];
  logic [2*W-1:0] exp_m   [NREQ];
  logic           exp_err [NREQ];
  int             exp_lat [NREQ];
  logic [NREQ-1:0] drop_mask = '0;
  logic [NREQ-1:0] keep_mask = '0;
  bit             prev_acc = 1'b0;
  int             cyc = 0;
  int             nchk = 0;
  int             nerr = 0;
  int             resp_cnt = 0;
  int             start_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe();
    sb_t          e;
    int           idx;
    bit           acc;
    logic [31:0]  onehot;
    acc = 1'b0;
    if (reset) begin
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        e.idx = idx;
        e.a   = req_a[idx*W +: W];
        e.b   = req_b[idx*W +: W];
        e.m   = exp_m[idx];
        e.err = exp_err[idx];
        e.lat = exp_lat[idx];
        e.acc = cyc;
        sbq.push_back(e);
        grant_log.push_back(idx);
        acc = 1'b1;
        if (!keep_mask[idx]) drop_mask[idx] = 1'b1;
      end
      if (mul_start) begin
        chk("start_after_accept", 32'(prev_acc), 32'd1);
        if (sbq.size() > 0) begin
          chk("mul_a_issue", 32'(mul_a), 32'(sbq[$].a));
          chk("mul_b_issue", 32'(mul_b), 32'(sbq[$].b));
        end
        start_cnt++;
      end
      if (resp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          onehot = 32'd1 << e.idx;
          chk("resp_owner", 32'(resp_valid), onehot);
          chk("resp_m", 32'(resp_m), 32'(e.m));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", cyc - e.acc, e.lat);
          chk("mul_a_stable", 32'(mul_a), 32'(e.a));
          chk("mul_b_stable", 32'(mul_b), 32'(e.b));
        end
        resp_cnt++;
      end
    end
    prev_acc = acc;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int target;
    int k;
    target = resp_cnt + n;
    k = 0;
    while (resp_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_budget", 32'(resp_cnt >= target), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] m, input logic err, input int el);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    exp_m[i]   = m;
    exp_err[i] = err;
    exp_lat[i] = el;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset     = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_m", 32'(resp_m), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    #19;
    req_valid = '0;
    sbq.delete();
    grant_log.delete();
    drop_mask = '0;
    keep_mask = '0;
    prev_acc  = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl[8];
  int   base;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      exp_m[i] = '0; exp_err[i] = 1'b0; exp_lat[i] = 0;
    end
    tbl[0] = '{0, 8'd7,   8'd3,   16'd21,    3};
    tbl[1] = '{1, 8'd12,  8'd5,   16'd60,    1};
    tbl[2] = '{2, 8'd255, 8'd255, 16'd65025, 5};
    tbl[3] = '{3, 8'd0,   8'd200, 16'd0,     2};
    tbl[4] = '{0, 8'd1,   8'd255, 16'd255,   1};
    tbl[5] = '{1, 8'd128, 8'd2,   16'd256,   4};
    tbl[6] = '{2, 8'd200, 8'd3,   16'd600,   1};
    tbl[7] = '{3, 8'd16,  8'd16,  16'd256,   2};

    // Reset state, then idle with no requests
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("idle_no_start", start_cnt, 0);
    chk("idle_no_resp", resp_cnt, 0);

    // Single operations from the table (entry 0 is requester 0, 7*3)
    for (int t = 0; t < 8; t++) begin
      lat = tbl[t].lat;
      set_req(tbl[t].idx, tbl[t].a, tbl[t].b, tbl[t].m, 1'b0, tbl[t].lat + 3);
      wait_resp(1, 60);
    end

    // Contention: all four at once, ptr back at 0 after requester 3's grant
    lat = 2;
    grant_log.delete();
    set_req(0, 8'd12,  8'd5,   16'd60,    1'b0, 5);
    set_req(1, 8'd25,  8'd10,  16'd250,   1'b0, 5);
    set_req(2, 8'd7,   8'd3,   16'd21,    1'b0, 5);
    set_req(3, 8'd100, 8'd100, 16'd10000, 1'b0, 5);
    wait_resp(4, 200);
    chk("contention_grants", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("contention_order", grant_log[i], i);

    // Reset in the middle of requester 2's WAIT: nothing comes back
    lat = 3;
    stub_dead = 1'b1;
    base = resp_cnt;
    set_req(2, 8'd9, 8'd9, 16'd81, 1'b0, 6);
    for (int k = 0; k < 8; k++) tick();
    req_valid[0] = 1'b1;
    #1;
    chk("busy_no_ready", 32'(req_ready), 32'd0);
    chk("mid_wait_no_resp", resp_cnt, base);
    do_reset();
    stub_dead = 1'b0;

    // Fairness from reset: 1 and 3 hold requests continuously (reuse in RESP cycle)
    lat = 1;
    keep_mask = 4'b1010;
    set_req(1, 8'd3, 8'd4, 16'd12, 1'b0, 4);
    set_req(3, 8'd5, 8'd6, 16'd30, 1'b0, 4);
    wait_resp(6, 100);
    keep_mask = '0;
    req_valid = '0;
    chk("fair_grants", 32'(grant_log.size() >= 6), 32'd1);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      chk("fair_order", grant_log[i], (i % 2 == 0) ? 1 : 3);
    for (int k = 0; k < 4; k++) tick();
    chk("fair_drained", 32'(sbq.size()), 32'd0);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // done in the same cycle the watchdog expires wins
    lat = 16;
    set_req(1, 8'd3, 8'd5, 16'd15, 1'b0, 19);
    wait_resp(1, 60);
    lat = 15;
    set_req(2, 8'd6, 8'd7, 16'd42, 1'b0, 18);
    wait_resp(1, 60);
    // No done at all: error response 17 cycles after entering WAIT
    stub_dead = 1'b1;
    set_req(0, 8'd9, 8'd9, 16'd0, 1'b1, TO + 3);
    wait_resp(1, 60);
    stub_dead = 1'b0;
`else
    // Without the watchdog WAIT holds indefinitely
    stub_dead = 1'b1;
    base = resp_cnt;
    set_req(0, 8'd9, 8'd9, 16'd81, 1'b0, 6);
    for (int k = 0; k < 100; k++) tick();
    chk("no_timeout_resp", resp_cnt, base);
    chk("no_timeout_err", 32'(resp_err), 32'd0);
    do_reset();
    stub_dead = 1'b0;
`endif

    // Normal operation after everything above
    lat = 2;
    set_req(2, 8'd11, 8'd13, 16'd143, 1'b0, 5);
    wait_resp(1, 40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", nerr);
    $fatal(1);
  end

endmodule
